serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor. Computes diff = a - b one bit per clock, LSB first.
- Built from a single full-subtractor cell plus a registered borrow flip-flop.
- Runs as a start/done handshaked coprocessor next to the combinational adder cells in the datapath library.
- Trades latency (WIDTH+1 cycles) for one-bit arithmetic hardware.

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop does the arithmetic.
// A start/done handshake wraps it so it can run beside the combinational
// datapath cells.
//
// Timing: start is accepted at edge k. SHIFT runs for WIDTH cycles. done
// pulses for one cycle after edge k+WIDTH. The earliest next start is
// accepted at edge k+WIDTH+2.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a      in   [WIDTH] minuend, captured on the accepting edge
//   b      in   [WIDTH] subtrahend, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, results valid
//   diff   out  [WIDTH] a - b modulo 2^WIDTH, held until the next DONE
//   bout   out  final borrow, 1 iff a < b (unsigned)
//   zero   out  1 iff diff == 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  // The counter only has to reach WIDTH-1. Keep it at least one bit wide.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;

  // Full-subtractor cell applied to the current LSBs and the stored borrow.
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] r_d;
  logic             last_bit;

  // NOTE: every signal driven here gets a value on every path. That is why
  // no latch is inferred.
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_d      = {d_bit, r_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // NOTE: the reset is asynchronous and active-low, so it sits in the
  // sensitivity list. All state uses non-blocking assignments, so every
  // register samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // Publish the result from the final cell output directly.
            // r_q only catches up on this same edge.
            diff_q  <= r_d;
            bout_q  <= br_d;
            zero_q  <= (r_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. It uses a WIDTH=8 instance for
// latency, handshake, hold, ignored-start and reset cases. A WIDTH=4
// instance is swept over every a/b pair, back to back.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, bout8, zero8;
  logic [7:0] diff8;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, bout4, zero4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8),
    .zero  (zero8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4),
    .zero  (zero4)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] last_diff = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation. It checks latency, busy length, a single done
  // pulse and the result. With pulse_ign it also fires stray starts in
  // SHIFT and DONE. With abort it pulses rst_n low in SHIFT cycle 4.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input logic ez,
                     input bit pulse_ign, input bit abort, input string tag);
    int busy_n;
    int done_n;
    int lat;
    logic [7:0] held;
    held = last_diff;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    // Edge k has passed; later operand changes must not matter.
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    busy_n = 0; done_n = 0; lat = -1;
    for (int i = 0; i < 14; i++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (lat < 0) begin
          lat = i;
          check({tag, " diff"}, 32'(diff8), 32'(ed));
          check({tag, " bout"}, 32'(bout8), 32'(eb));
          check({tag, " zero"}, 32'(zero8), 32'(ez));
        end
      end
      if (i == 4 && !abort) check({tag, " hold"}, 32'(diff8), 32'(held));
      if (pulse_ign && (i == 2 || i == 8)) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (abort && i == 3) begin
        rst_n = 1'b0;
        #1;
        check({tag, " abort busy"}, 32'(busy8), 32'd0);
        check({tag, " abort diff"}, 32'(diff8), 32'd0);
        check({tag, " abort bout"}, 32'(bout8), 32'd0);
      end
      if (abort && i == 4) rst_n = 1'b1;
      @(negedge clk);
    end
    start8 = 1'b0;
    if (abort) begin
      check({tag, " no done"}, 32'(done_n), 32'd0);
      check({tag, " diff after abort"}, 32'(diff8), 32'd0);
      last_diff = '0;
    end else begin
      check({tag, " latency"}, 32'(lat), 32'd8);
      check({tag, " busy cycles"}, 32'(busy_n), 32'd8);
      check({tag, " done pulses"}, 32'(done_n), 32'd1);
      last_diff = ed;
    end
  endtask

  initial begin
    // Reset held for two cycles.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst diff", 32'(diff8), 32'd0);
    check("rst bout", 32'(bout8), 32'd0);
    check("rst zero", 32'(zero8), 32'd0);
    rst_n = 1'b1;

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "5-3");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, "3-5");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "0-1");

    // Asynchronous reset mid-cycle, with no clock edge before the check.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async diff", 32'(diff8), 32'd0);
    check("async bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0;

    op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "FF-FF");
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, "ignore");
    op8(8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "abort");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, "after abort");

    // Exhaustive WIDTH=4 sweep, issuing each start as soon as IDLE returns.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [3:0] ed4;
        ed4 = 4'(ia - ib);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib);
        @(negedge clk);
        start4 = 1'b0;
        for (int w = 0; w < 10 && !done4; w++) @(negedge clk);
        if (!done4) begin
          check("w4 timeout", 32'(done4), 32'd1);
        end else begin
          check("w4 diff", 32'(diff4), 32'(ed4));
          check("w4 bout", 32'(bout4), 32'(ia < ib));
          check("w4 zero", 32'(zero4), 32'(ed4 == 4'd0));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
